// File: rtl/difficulty_select.sv
// Turns raw active-low KEY[3:1] pushbuttons into a registered one-hot difficulty
// selection: two-flop sync, per-key debounce, press detect, lockable select FSM.
module difficulty_select #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  input  logic       game_active,
  output logic [2:0] diff,
  output logic       diff_changed
);

  typedef enum logic {
    SELECT = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            deb_q, deb_d;
  logic [2:0]            press_q, press_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic [2:0]            diff_q, diff_d;
  logic                  chg_q, chg_d;

  // Simultaneous presses resolve to the lowest index (easy > medium > hard).
  function automatic logic [2:0] lowest_onehot(input logic [2:0] p);
    if (p[0]) return 3'b001;
    if (p[1]) return 3'b010;
    return 3'b100;
  endfunction

  // Debounce: a bit is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    press_d = deb_q & ~deb_d;
  end

  always_comb begin
    state_d = state_q;
    diff_d  = diff_q;
    chg_d   = 1'b0;
    case (state_q)
      SELECT: begin
        if (press_q != 3'b000) begin
          diff_d = lowest_onehot(press_q);
          chg_d  = (diff_d != diff_q);
        end
        if (game_active) state_d = LOCKED;
      end
      LOCKED: begin
        if (!game_active) state_d = SELECT;
      end
      default: state_d = SELECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      deb_q   <= 3'b111;
      cnt_q   <= '0;
      press_q <= 3'b000;
      state_q <= SELECT;
      diff_q  <= 3'b001;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      state_q <= state_d;
      diff_q  <= diff_d;
      chg_q   <= chg_d;
    end
  end

  assign diff         = diff_q;
  assign diff_changed = chg_q;

endmodule

// File: tb/tb_difficulty_select.sv
// Bench for difficulty_select: directed scenarios plus randomized key/lock traffic,
// compared every cycle against a sample-history reference model.
module tb_difficulty_select;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic       game_active;
  logic [2:0] diff;
  logic       diff_changed;

  int n_vec = 0;
  int n_err = 0;
  int tc    = 0;

  // Reference state: kh[0] is the key_n sampled on the most recent edge.
  logic [2:0] kh [8];
  logic [2:0] m_deb, m_press, m_diff;
  logic       m_chg, m_lock;

  difficulty_select #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .game_active  (game_active),
    .diff         (diff),
    .diff_changed (diff_changed)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, tc);
    end
  endtask

  // A key level is accepted once the last D synchronised samples (key_n from two
  // edges back and earlier) all disagree with the accepted level. A press applies
  // only if game_active was low on the previous edge.
  task automatic model_edge();
    logic [2:0] nd;
    if (reset) begin
      for (int i = 0; i < 8; i++) kh[i] = 3'b111;
      m_deb = 3'b111; m_press = 3'b000; m_diff = 3'b001; m_chg = 1'b0; m_lock = 1'b0;
      return;
    end
    m_chg = 1'b0;
    if (!m_lock && m_press != 3'b000) begin
      logic [2:0] pick;
      pick = 3'b000;
      for (int b = 2; b >= 0; b--) if (m_press[b]) pick = 3'(1 << b);
      m_chg  = (pick != m_diff);
      m_diff = pick;
    end
    m_lock = game_active;
    for (int i = 7; i > 0; i--) kh[i] = kh[i-1];
    kh[0] = key_n;
    nd = m_deb;
    for (int b = 0; b < 3; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 2; j < 2 + D; j++) if (kh[j][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_deb[b];
    end
    m_press = m_deb & ~nd;
    m_deb   = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    tc++;
    @(negedge clk);
    chk_val("diff", int'(diff), int'(m_diff));
    chk_val("diff_changed", int'(diff_changed), int'(m_chg));
    chk_val("onehot", $countones(diff), 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
  endtask

  initial begin
    int t0, first, pulses;
    reset = 1'b1; key_n = 3'b111; game_active = 1'b0;
    @(negedge clk);

    // reset with idle keys
    do_reset();
    run(8);
    chk_val("idle_diff", int'(diff), 1);

    // hard press: exact latency and one pulse, release gives nothing
    key_n = 3'b011; t0 = tc; first = -1; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (diff == 3'b100 && first < 0) first = tc - t0;
      if (diff_changed) pulses++;
    end
    chk_val("hard_latency", first, D + 3);
    key_n = 3'b111;
    for (int i = 0; i < 12; i++) begin tick(); if (diff_changed) pulses++; end
    chk_val("hard_pulses", pulses, 1);
    chk_val("hard_after_release", int'(diff), 4);

    // short glitch on medium
    do_reset();
    key_n = 3'b101; pulses = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (diff_changed) pulses++; end
    key_n = 3'b111;
    for (int i = 0; i < 12; i++) begin tick(); if (diff_changed) pulses++; end
    chk_val("glitch_pulses", pulses, 0);
    chk_val("glitch_diff", int'(diff), 1);

    // locked presses ignored, unlocked applied
    do_reset();
    game_active = 1'b1; run(2);
    key_n = 3'b101; run(12);
    key_n = 3'b111; run(10);
    chk_val("locked_diff", int'(diff), 1);
    game_active = 1'b0; run(2);
    key_n = 3'b101; run(12);
    key_n = 3'b111; run(10);
    chk_val("unlocked_diff", int'(diff), 2);

    // all keys at once from hard: easy wins, one pulse
    do_reset();
    key_n = 3'b011; run(12);
    key_n = 3'b111; run(10);
    key_n = 3'b000; pulses = 0;
    for (int i = 0; i < 14; i++) begin tick(); if (diff_changed) pulses++; end
    chk_val("multi_diff", int'(diff), 1);
    chk_val("multi_pulses", pulses, 1);
    key_n = 3'b111; run(10);

    // reset mid-debounce with key held through it
    do_reset();
    key_n = 3'b011; run(5);
    reset = 1'b1; tick();
    chk_val("midreset_diff", int'(diff), 1);
    reset = 1'b0; t0 = tc; first = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (diff == 3'b100 && first < 0) first = tc - t0;
    end
    chk_val("held_reset_latency", first, D + 3);
    key_n = 3'b111; run(10);

    // randomized traffic
    for (int s = 0; s < 300; s++) begin
      int r;
      r = $urandom_range(0, 9);
      key_n = (r < 4) ? 3'b111 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) game_active = ~game_active;
      reset = ($urandom_range(0, 40) == 0);
      run($urandom_range(1, 12));
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
